// File: rtl/noc_rr_packet_arbiter.sv
// noc_rr_packet_arbiter
//   Round-robin, packet-locked arbiter for one NoC router output port.
//   It sits between the input VC buffers and the crossbar select.
//   In IDLE it picks the lowest requester at or above the rotating mask.
//   If no masked requester exists, it picks the lowest requester overall.
//   The grant is held (LOCK) until the winner's tail flit transfers.
//   After that there is one IDLE bubble cycle before the next grant.
//
// Optional feature macro: NOC_ARB_GRANT_CNT_EN
//   When defined, per-input saturating grant counters are added.
//   They are exposed on the grant_cnt port.
//
// Ports
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   req        per-input "has a flit for this output"
//   tail       per-input "current flit is the last of its packet"
//   out_ready  downstream accepts a flit this cycle
//   gnt        registered one-hot grant, zero when idle
//   gnt_valid  registered |gnt
//   gnt_idx    registered binary index of the granted input, zero when idle
//   grant_cnt  packed counters, counter i at [i*CNT_W +: CNT_W]
//              (only present with NOC_ARB_GRANT_CNT_EN)
module noc_rr_packet_arbiter #(
  parameter  int REQ_NUM = 5,
  parameter  int CNT_W   = 16,
  localparam int IDX_W   = $clog2(REQ_NUM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REQ_NUM-1:0]       req,
  input  logic [REQ_NUM-1:0]       tail,
  input  logic                     out_ready,
  output logic [REQ_NUM-1:0]       gnt,
  output logic                     gnt_valid,
  output logic [IDX_W-1:0]         gnt_idx
`ifdef NOC_ARB_GRANT_CNT_EN
  ,
  output logic [REQ_NUM*CNT_W-1:0] grant_cnt
`endif
);

  // Reject unsupported configurations at elaboration time.
  if (REQ_NUM < 2 || REQ_NUM > 16 || CNT_W < 1) begin : g_param_check
    $error("noc_rr_packet_arbiter: unsupported REQ_NUM or CNT_W");
  end

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [REQ_NUM-1:0] ONE = REQ_NUM'(1);

  state_t             state_reg, state_next;
  logic [REQ_NUM-1:0] mask_reg, mask_next;
  logic [REQ_NUM-1:0] gnt_reg, gnt_next;
  logic               gnt_valid_reg, gnt_valid_next;
  logic [IDX_W-1:0]   gnt_idx_reg, gnt_idx_next;

  logic [REQ_NUM-1:0] masked_req;
  logic [REQ_NUM-1:0] pick_vec;
  logic [REQ_NUM-1:0] winner;
  logic [IDX_W-1:0]   winner_idx;
  logic [REQ_NUM-1:0] above_gnt;
  logic               tail_xfer;

  // Lowest-set-bit one-hot over the masked vector, falling back to all requests.
  assign masked_req = req & mask_reg;
  assign pick_vec   = (masked_req != '0) ? masked_req : req;
  assign winner     = pick_vec & (~pick_vec + ONE);

  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (winner[i]) winner_idx = winner_idx | IDX_W'(i);
    end
  end

  // Bits strictly above the current one-hot grant.
  // This is zero when the top input wins; that case wraps the mask to all ones.
  assign above_gnt = ~(gnt_reg | (gnt_reg - ONE));

  // Release happens only on a real transfer of the winner's tail flit.
  assign tail_xfer = out_ready & (|(gnt_reg & req & tail));

  always_comb begin
    state_next     = state_reg;
    mask_next      = mask_reg;
    gnt_next       = gnt_reg;
    gnt_valid_next = gnt_valid_reg;
    gnt_idx_next   = gnt_idx_reg;
    case (state_reg)
      IDLE: begin
        if (req != '0) begin
          state_next     = LOCK;
          gnt_next       = winner;
          gnt_valid_next = 1'b1;
          gnt_idx_next   = winner_idx;
        end
      end
      LOCK: begin
        if (tail_xfer) begin
          state_next     = IDLE;
          gnt_next       = '0;
          gnt_valid_next = 1'b0;
          gnt_idx_next   = '0;
          mask_next      = (above_gnt == '0) ? '1 : above_gnt;
        end
      end
      default: begin
        state_next     = IDLE;
        gnt_next       = '0;
        gnt_valid_next = 1'b0;
        gnt_idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mask_reg      <= '1;
      gnt_reg       <= '0;
      gnt_valid_reg <= 1'b0;
      gnt_idx_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      mask_reg      <= mask_next;
      gnt_reg       <= gnt_next;
      gnt_valid_reg <= gnt_valid_next;
      gnt_idx_reg   <= gnt_idx_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = gnt_valid_reg;
  assign gnt_idx   = gnt_idx_reg;

`ifdef NOC_ARB_GRANT_CNT_EN
  // A grant event is an IDLE->LOCK transition; winner marks the input served.
  logic grant_event;
  assign grant_event = (state_reg == IDLE) && (req != '0);

  for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_grant_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (grant_event && winner[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
    assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_noc_rr_packet_arbiter.sv
module tb_noc_rr_packet_arbiter;
  localparam int N     = 5;
  localparam int CNT_W = 16;
  localparam int IDX_W = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req, tail;
  logic             out_ready;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
`ifdef NOC_ARB_GRANT_CNT_EN
  logic [N*CNT_W-1:0] grant_cnt;
`endif

  noc_rr_packet_arbiter #(.REQ_NUM(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .tail      (tail),
    .out_ready (out_ready),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
`ifdef NOC_ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: which input owns the port (-1 when idle) and where the
  // next round-robin search starts.
  int owner = -1;
  int start_ptr = 0;
  longint model_cnt [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model advance for one clock edge, using the inputs presented before it.
  task automatic model_edge(input bit r_n, input logic [N-1:0] rq,
                            input logic [N-1:0] tl, input bit rdy);
    if (!r_n) begin
      owner = -1;
      start_ptr = 0;
      for (int i = 0; i < N; i++) model_cnt[i] = 0;
    end else if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (start_ptr + k) % N;
        if (owner < 0 && rq[c]) owner = c;
      end
      if (owner >= 0 && model_cnt[owner] < (64'd1 << CNT_W) - 1)
        model_cnt[owner]++;
    end else if (rq[owner] && tl[owner] && rdy) begin
      start_ptr = (owner + 1) % N;
      owner = -1;
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic step(input bit r_n, input logic [N-1:0] rq,
                      input logic [N-1:0] tl, input bit rdy);
    logic [N-1:0] exp_gnt;
    rst_n = r_n; req = rq; tail = tl; out_ready = rdy;
    model_edge(r_n, rq, tl, rdy);
    @(posedge clk);
    @(negedge clk);
    exp_gnt = (owner < 0) ? '0 : N'(1) << owner;
    chk("model_gnt", 32'(gnt), 32'(exp_gnt));
    chk("model_gnt_valid", 32'(gnt_valid), 32'(owner >= 0));
    chk("model_gnt_idx", 32'(gnt_idx), (owner < 0) ? 32'd0 : 32'(owner));
`ifdef NOC_ARB_GRANT_CNT_EN
    for (int i = 0; i < N; i++)
      chk("model_grant_cnt", 32'(grant_cnt[i*CNT_W +: CNT_W]), 32'(model_cnt[i]));
`endif
    $display("t=%0t rst_n=%0b req=%b tail=%b rdy=%0b -> gnt=%b idx=%0d", $time, r_n, rq, tl, rdy, gnt, gnt_idx);
  endtask

  initial begin
    logic [N-1:0] rot_exp [7];
    int ready_pat [6];
    rst_n = 1'b0; req = '0; tail = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) model_cnt[i] = 0;
    @(negedge clk);

    // Reset held two cycles with all inputs requesting.
    for (int k = 0; k < 2; k++) begin
      step(0, 5'b11111, 5'b11111, 1);
      chk("reset_gnt", 32'(gnt), 32'd0);
      chk("reset_valid", 32'(gnt_valid), 32'd0);
      chk("reset_idx", 32'(gnt_idx), 32'd0);
    end

    // Rotation over inputs 0,2,4 with single-flit packets.
    rot_exp = '{5'b00001, 5'b00000, 5'b00100, 5'b00000, 5'b10000, 5'b00000, 5'b00001};
    for (int k = 0; k < 7; k++) begin
      step(1, 5'b10101, 5'b11111, 1);
      chk("rotation_gnt", 32'(gnt), 32'(rot_exp[k]));
    end

    // Four-flit packet on input 0, downstream stalling intermittently.
    step(0, '0, '0, 0);
    step(1, 5'b00011, 5'b00000, 0);
    chk("lock_first_gnt", 32'(gnt), 32'd1);
    ready_pat = '{1, 0, 1, 1, 0, 1};
    for (int k = 0; k < 6; k++) begin
      step(1, 5'b00011, (k == 5) ? 5'b00011 : 5'b00000, ready_pat[k][0]);
      chk("lock_gnt", 32'(gnt), (k == 5) ? 32'd0 : 32'd1);
    end
    step(1, 5'b00011, 5'b00000, 0);
    chk("lock_next_gnt", 32'(gnt), 32'd2);
    chk("lock_next_idx", 32'(gnt_idx), 32'd1);

    // Tail presented while stalled is ignored until it actually transfers.
    step(0, '0, '0, 0);
    step(1, 5'b00100, 5'b00000, 0);
    chk("stall_gnt", 32'(gnt), 32'd4);
    for (int k = 0; k < 3; k++) begin
      step(1, 5'b00100, 5'b00100, 0);
      chk("stall_hold_gnt", 32'(gnt), 32'd4);
    end
    step(1, 5'b00100, 5'b00100, 1);
    chk("stall_release_gnt", 32'(gnt), 32'd0);

    // Mid-packet reset drops the grant and restores input 0 as highest priority.
    step(0, '0, '0, 0);
    step(1, 5'b01000, 5'b00000, 1);
    chk("midrst_lock_gnt", 32'(gnt), 32'd8);
    step(0, 5'b01000, 5'b00000, 1);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    step(1, 5'b01001, 5'b00000, 0);
    chk("midrst_after_gnt", 32'(gnt), 32'd1);

`ifdef NOC_ARB_GRANT_CNT_EN
    // Ten single-flit grants alternating between inputs 0 and 1.
    step(0, '0, '0, 0);
    for (int k = 0; k < 20; k++) step(1, 5'b00011, 5'b00011, 1);
    chk("cnt0", 32'(grant_cnt[0 +: CNT_W]), 32'd5);
    chk("cnt1", 32'(grant_cnt[CNT_W +: CNT_W]), 32'd5);
`endif

    // Randomised traffic, including stalls, dropped requests and occasional resets.
    for (int k = 0; k < 600; k++) begin
      bit r_n;
      logic [N-1:0] rq, tl;
      bit rdy;
      r_n = ($urandom_range(0, 63) != 0);
      rq  = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 3) == 0) rq = '0;
      tl  = N'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      step(r_n, rq, tl, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
